// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Ed25519 scalar multiplication.
// Issues doubling/addition jobs to the point-add engine and accumulates Q.
module scalar_mult_ctrl #(
    parameter int unsigned W   = 255,
    parameter logic [W-1:0] ONE = W'('h26)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_k,
    input  logic [W-1:0] i_px,
    input  logic [W-1:0] i_py,
    input  logic [W-1:0] i_pz,
    input  logic [W-1:0] i_pt,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_qx,
    output logic [W-1:0] o_qy,
    output logic [W-1:0] o_qz,
    output logic [W-1:0] o_qt,
    output logic         o_pa_start,
    output logic         o_pa_doubling,
    output logic         o_pa_initial,
    output logic [W-1:0] o_pa_x1,
    output logic [W-1:0] o_pa_y1,
    output logic [W-1:0] o_pa_z1,
    output logic [W-1:0] o_pa_t1,
    output logic [W-1:0] o_pa_x2,
    output logic [W-1:0] o_pa_y2,
    output logic [W-1:0] o_pa_z2,
    output logic [W-1:0] o_pa_t2,
    input  logic [W-1:0] i_pa_x3,
    input  logic [W-1:0] i_pa_y3,
    input  logic [W-1:0] i_pa_z3,
    input  logic [W-1:0] i_pa_t3,
    input  logic         i_pa_finished
);
    localparam int unsigned IW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE, SCAN, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, FIN
    } state_t;

    // Points are packed as {t, z, y, x}: index 0 = x ... index 3 = t.
    typedef logic [3:0][W-1:0] point_t;

    state_t          state_q, state_d;
    logic [W-1:0]    k_q, k_d;
    logic [IW-1:0]   idx_q, idx_d;
    point_t          p_q, p_d;
    point_t          acc_q, acc_d;
    point_t          res_q, res_d;
    point_t          op1_q, op1_d;
    point_t          op2_q, op2_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            start_q, start_d;
    logic            dbl_q, dbl_d;

    point_t          pa_res;
    point_t          neutral;
    logic            last_bit;

    assign pa_res   = {i_pa_t3, i_pa_z3, i_pa_y3, i_pa_x3};
    assign neutral  = {{W{1'b0}}, ONE, ONE, {W{1'b0}}};
    assign last_bit = (idx_q == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            dbl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            dbl_q   <= dbl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        p_d     = p_q;
        acc_d   = acc_q;
        res_d   = res_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        busy_d  = (state_q != IDLE);
        done_d  = 1'b0;
        start_d = 1'b0;
        dbl_d   = dbl_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    k_d     = i_k;
                    p_d     = {i_pt, i_pz, i_py, i_px};
                    idx_d   = IW'(W - 1);
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            // Leading zeros are skipped without engine work; the first set bit seeds Q with P.
            SCAN: begin
                if (k_q[idx_q]) begin
                    acc_d = p_q;
                    if (last_bit) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = DBL_ISSUE;
                    end
                end else if (last_bit) begin
                    acc_d   = neutral;
                    state_d = FIN;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DBL_ISSUE: begin
                op1_d   = acc_q;
                op2_d   = acc_q;
                dbl_d   = 1'b1;
                start_d = 1'b1;
                state_d = DBL_WAIT;
            end
            DBL_WAIT: begin
                if (i_pa_finished) begin
                    acc_d = pa_res;
                    if (k_q[idx_q]) begin
                        state_d = ADD_ISSUE;
                    end else if (last_bit) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = DBL_ISSUE;
                    end
                end
            end
            ADD_ISSUE: begin
                op1_d   = acc_q;
                op2_d   = p_q;
                dbl_d   = 1'b0;
                start_d = 1'b1;
                state_d = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (i_pa_finished) begin
                    acc_d = pa_res;
                    if (last_bit) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = DBL_ISSUE;
                    end
                end
            end
            FIN: begin
                res_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_qx          = res_q[0];
    assign o_qy          = res_q[1];
    assign o_qz          = res_q[2];
    assign o_qt          = res_q[3];
    assign o_pa_start    = start_q;
    assign o_pa_doubling = dbl_q;
    assign o_pa_initial  = 1'b0;
    assign o_pa_x1       = op1_q[0];
    assign o_pa_y1       = op1_q[1];
    assign o_pa_z1       = op1_q[2];
    assign o_pa_t1       = op1_q[3];
    assign o_pa_x2       = op2_q[0];
    assign o_pa_y2       = op2_q[1];
    assign o_pa_z2       = op2_q[2];
    assign o_pa_t2       = op2_q[3];

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl with a fixed-latency behavioural
// point-add engine (result = operand1 + 1000 for doubling, + 1 for addition).
module tb_scalar_mult_ctrl;
    localparam int unsigned W = 255;
    localparam logic [W-1:0] ONE = W'('h26);

    logic         i_clk = 1'b0;
    logic         i_rst, i_start;
    logic [W-1:0] i_k, i_px, i_py, i_pz, i_pt;
    logic         o_busy, o_done;
    logic [W-1:0] o_qx, o_qy, o_qz, o_qt;
    logic         o_pa_start, o_pa_doubling, o_pa_initial;
    logic [W-1:0] o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1;
    logic [W-1:0] o_pa_x2, o_pa_y2, o_pa_z2, o_pa_t2;
    logic [W-1:0] i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3;
    logic         i_pa_finished;

    scalar_mult_ctrl #(.W(W), .ONE(ONE)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_k(i_k),
        .i_px(i_px), .i_py(i_py), .i_pz(i_pz), .i_pt(i_pt),
        .o_busy(o_busy), .o_done(o_done),
        .o_qx(o_qx), .o_qy(o_qy), .o_qz(o_qz), .o_qt(o_qt),
        .o_pa_start(o_pa_start), .o_pa_doubling(o_pa_doubling), .o_pa_initial(o_pa_initial),
        .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1), .o_pa_z1(o_pa_z1), .o_pa_t1(o_pa_t1),
        .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2), .o_pa_z2(o_pa_z2), .o_pa_t2(o_pa_t2),
        .i_pa_x3(i_pa_x3), .i_pa_y3(i_pa_y3), .i_pa_z3(i_pa_z3), .i_pa_t3(i_pa_t3),
        .i_pa_finished(i_pa_finished)
    );

    always #5 i_clk = ~i_clk;

    // Engine model and job monitor, all bookkeeping cumulative.
    int           n_start = 0, n_dbl = 0, n_add = 0;
    int           alt_err = 0, stab_err = 0, overlap_err = 0;
    int           eng_cnt = 0;
    logic         outstanding = 1'b0, last_dbl = 1'b0, have_last = 1'b0;
    logic         spur_arm = 1'b0, spur_done = 1'b0, spur_pend = 1'b0;
    logic [W-1:0] l_x1, l_y1, l_z1, l_t1, l_x2, l_y2, l_z2, l_t2, tag;

    always @(negedge i_clk) begin
        if (outstanding &&
            {o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1, o_pa_x2, o_pa_y2, o_pa_z2, o_pa_t2} !==
            {l_x1, l_y1, l_z1, l_t1, l_x2, l_y2, l_z2, l_t2})
            stab_err++;
        i_pa_finished = 1'b0;
        if (eng_cnt != 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                i_pa_finished = 1'b1;
                i_pa_x3 = l_x1 + tag; i_pa_y3 = l_y1 + tag;
                i_pa_z3 = l_z1 + tag; i_pa_t3 = l_t1 + tag;
                outstanding = 1'b0;
                if (spur_arm && !spur_done) begin
                    spur_pend = 1'b1;
                    spur_done = 1'b1;
                end
            end
        end else if (spur_pend) begin
            // Extra finish pulse lands while the DUT sits in an ISSUE state.
            i_pa_finished = 1'b1;
            i_pa_x3 = 5000; i_pa_y3 = 5000; i_pa_z3 = 5000; i_pa_t3 = 5000;
            spur_pend = 1'b0;
        end
        if (o_pa_start === 1'b1) begin
            n_start++;
            if (outstanding) overlap_err++;
            if (have_last && (last_dbl == o_pa_doubling)) alt_err++;
            have_last = 1'b1;
            last_dbl  = o_pa_doubling;
            if (o_pa_doubling) n_dbl++; else n_add++;
            {l_x1, l_y1, l_z1, l_t1} = {o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1};
            {l_x2, l_y2, l_z2, l_t2} = {o_pa_x2, o_pa_y2, o_pa_z2, o_pa_t2};
            tag = o_pa_doubling ? W'(1000) : W'(1);
            eng_cnt = 10;
            outstanding = 1'b1;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic start_job(input logic [W-1:0] k, input logic [W-1:0] px, input logic [W-1:0] py,
                             input logic [W-1:0] pz, input logic [W-1:0] pt);
        i_k = k; i_px = px; i_py = py; i_pz = pz; i_pt = pt;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Returns edges elapsed since the accepting edge when o_done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (o_done !== 1'b1 && lat < 30000) begin
            @(negedge i_clk);
            lat++;
        end
        chk("done_within_budget", W'(lat < 30000), W'(1));
    endtask

    int lat, s_st, s_dbl, s_add, s_alt, s_stab, s_ovl, wcnt;
    logic [W-1:0] k_top, k_ones;

    initial begin
        i_rst = 1'b1; i_start = 1'b0;
        i_k = '0; i_px = '0; i_py = '0; i_pz = '0; i_pt = '0;
        i_pa_x3 = '0; i_pa_y3 = '0; i_pa_z3 = '0; i_pa_t3 = '0;
        i_pa_finished = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;

        chk("rst_busy", W'(o_busy), W'(0));
        chk("rst_done", W'(o_done), W'(0));
        chk("rst_qy", o_qy, '0);
        chk("rst_pa_start", W'(o_pa_start), W'(0));
        chk("rst_pa_x1", o_pa_x1, '0);
        chk("pa_initial", W'(o_pa_initial), W'(0));

        // k = 0: neutral point, no engine jobs, done at accept+256
        s_st = n_start;
        start_job('0, 11, 22, 33, 44);
        chk("k0_busy_after_accept", W'(o_busy), W'(1));
        wait_done(lat);
        chk("k0_latency", W'(lat), W'(256));
        chk("k0_qx", o_qx, '0);
        chk("k0_qy", o_qy, ONE);
        chk("k0_qz", o_qz, ONE);
        chk("k0_qt", o_qt, '0);
        chk("k0_busy_at_done", W'(o_busy), W'(1));
        @(negedge i_clk);
        chk("k0_done_pulse_len", W'(o_done), W'(0));
        chk("k0_busy_drop", W'(o_busy), W'(0));
        chk("k0_jobs", W'(n_start - s_st), W'(0));

        // k = 1: Q = P, no engine jobs
        s_st = n_start;
        start_job(W'(1), 5, 7, 1, 35);
        wait_done(lat);
        chk("k1_latency", W'(lat), W'(256));
        chk("k1_qx", o_qx, W'(5));
        chk("k1_qy", o_qy, W'(7));
        chk("k1_qz", o_qz, W'(1));
        chk("k1_qt", o_qt, W'(35));
        chk("k1_jobs", W'(n_start - s_st), W'(0));

        // k = 3: double then add
        s_st = n_start; s_dbl = n_dbl; s_add = n_add;
        start_job(W'(3), 100, 200, 1, 300);
        wait_done(lat);
        chk("k3_qx", o_qx, W'(1101));
        chk("k3_qy", o_qy, W'(1201));
        chk("k3_qz", o_qz, W'(1002));
        chk("k3_qt", o_qt, W'(1301));
        chk("k3_jobs", W'(n_start - s_st), W'(2));
        chk("k3_dbl", W'(n_dbl - s_dbl), W'(1));
        chk("k3_add", W'(n_add - s_add), W'(1));
        chk("k3_last_is_add", W'(last_dbl), W'(0));

        // k = 2^254: 254 doublings only
        k_top = '0; k_top[254] = 1'b1;
        s_dbl = n_dbl; s_add = n_add; s_stab = stab_err;
        start_job(k_top, 7, 8, 9, 10);
        wait_done(lat);
        chk("top_qx", o_qx, W'(254007));
        chk("top_qt", o_qt, W'(254010));
        chk("top_dbl", W'(n_dbl - s_dbl), W'(254));
        chk("top_add", W'(n_add - s_add), W'(0));
        chk("top_stable", W'(stab_err - s_stab), W'(0));

        // k = all ones: strictly alternating D,A
        k_ones = '1;
        @(negedge i_clk);
        s_dbl = n_dbl; s_add = n_add; s_stab = stab_err; s_ovl = overlap_err;
        have_last = 1'b0;
        s_alt = alt_err;
        start_job(k_ones, 3, 4, 5, 6);
        wait_done(lat);
        chk("ones_qx", o_qx, W'(254257));
        chk("ones_qz", o_qz, W'(254259));
        chk("ones_dbl", W'(n_dbl - s_dbl), W'(254));
        chk("ones_add", W'(n_add - s_add), W'(254));
        chk("ones_alternate", W'(alt_err - s_alt), W'(0));
        chk("ones_stable", W'(stab_err - s_stab), W'(0));
        chk("ones_one_outstanding", W'(overlap_err - s_ovl), W'(0));

        // Second start mid-run and a spurious finish during ISSUE
        spur_arm = 1'b1;
        s_st = n_start;
        start_job(W'(3), 100, 200, 1, 300);
        repeat (5) @(negedge i_clk);
        start_job(W'(7), 9, 9, 9, 9);
        wait_done(lat);
        chk("mid_spur_seen", W'(spur_done), W'(1));
        chk("mid_qx", o_qx, W'(1101));
        chk("mid_qy", o_qy, W'(1201));
        chk("mid_jobs", W'(n_start - s_st), W'(2));
        repeat (300) @(negedge i_clk);
        chk("mid_no_second_run", W'(o_busy), W'(0));
        chk("mid_jobs_after", W'(n_start - s_st), W'(2));

        // Reset during DBL_WAIT, then late engine finish
        s_st = n_start;
        start_job(W'(3), 1000, 2000, 3000, 4000);
        wcnt = 0;
        while (n_start == s_st && wcnt < 400) begin
            @(negedge i_clk);
            wcnt++;
        end
        chk("rst_job_issued", W'(wcnt < 400), W'(1));
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("abort_busy", W'(o_busy), W'(0));
        chk("abort_qx", o_qx, '0);
        chk("abort_pa_doubling", W'(o_pa_doubling), W'(0));
        chk("abort_pa_y2", o_pa_y2, '0);
        repeat (20) @(negedge i_clk);
        chk("late_fin_busy", W'(o_busy), W'(0));
        chk("late_fin_done", W'(o_done), W'(0));
        chk("late_fin_qx", o_qx, '0);
        chk("late_fin_jobs", W'(n_start - s_st), W'(1));

        s_st = n_start;
        start_job(W'(3), 1000, 2000, 3000, 4000);
        wait_done(lat);
        chk("fresh_qx", o_qx, W'(2001));
        chk("fresh_qt", o_qt, W'(5001));
        chk("fresh_jobs", W'(n_start - s_st), W'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Sequencer for Ed25519 scalar multiplication Q = k·P using left-to-right double-and-add.
- Sits upstream of the extended-coordinate point-add engine: issues doubling and addition jobs to it, consumes each result, and accumulates Q.
- All coordinates are opaque 255-bit field words in the engine's domain; this block performs no field arithmetic.

Parameters:
- W, 255, coordinate and scalar width
- ONE, 255'h26, engine-domain representation of field element 1 (R mod p), used for the neutral point

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- i_k  in  W  scalar, sampled with i_start
- i_px, i_py, i_pz, i_pt  in  W each  base point P (extended coords), sampled with i_start
- o_busy  out  1  high from accept until done pulse (inclusive)
- o_done  out  1  one-cycle completion pulse
- o_qx, o_qy, o_qz, o_qt  out  W each  result Q, valid from o_done until next accept
- o_pa_start  out  1  one-cycle job pulse to engine
- o_pa_doubling  out  1  1 = doubling job, 0 = addition job
- o_pa_initial  out  1  tied 0
- o_pa_x1..o_pa_t1  out  W each  engine operand 1 (always accumulator Q)
- o_pa_x2..o_pa_t2  out  W each  engine operand 2 (P for add; copy of Q for double)
- i_pa_x3..i_pa_t3  in  W each  engine result
- i_pa_finished  in  1  engine done pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including o_q*, o_busy, o_done, o_pa_start, and all operand buses. Internal registers are cleared.
- Reset mid-operation: abort immediately to IDLE; any later i_pa_finished is ignored.
- IDLE: on i_start, latch k, P, idx=W-1 → SCAN. o_busy rises the cycle after the accepting edge.
- i_start while busy: ignored, with no effect on the running job.
- SCAN (one bit per cycle):
  - k[idx]=1 → Q=P. If idx==0 → FIN, else idx-- → DBL_ISSUE.
  - k[idx]=0 → if idx==0 → Q=(0,ONE,ONE,0) and FIN, else idx--.
- DBL_ISSUE: drive operands (Q,Q), doubling=1, pulse o_pa_start for one cycle → DBL_WAIT.
- DBL_WAIT: on i_pa_finished, Q=result. If k[idx]=1 → ADD_ISSUE; else if idx==0 → FIN; else idx-- → DBL_ISSUE.
- ADD_ISSUE: operands (Q,P), doubling=0, one-cycle o_pa_start → ADD_WAIT.
- ADD_WAIT: on i_pa_finished, Q=result. If idx==0 → FIN, else idx-- → DBL_ISSUE.
- FIN: register Q onto o_q*, pulse o_done, → IDLE. o_busy drops the cycle after o_done.
- Engine handshake:
  - Operand buses are registered and held stable from o_pa_start until the matching i_pa_finished.
  - Never more than one job outstanding.
  - i_pa_finished outside a WAIT state is ignored.
  - No timeout; this block waits indefinitely.
- Operation count for nonzero k with MSB index m:
  - doublings = m
  - additions = popcount(k) − 1
- Latency:
  - k ∈ {0,1}: o_done high exactly 256 cycles after the accepting edge (255 SCAN cycles + FIN).
  - General case: scan cycles + per job (2 + engine latency) + 1.

Test Plan:
- k=0, P arbitrary → no o_pa_start pulses; o_done at accept+256; Q=(0,ONE,ONE,0).
- k=1, P=(5,7,1,35) → no engine jobs; o_done at accept+256; Q=(5,7,1,35).
- Behavioural engine model: fixed 10-cycle latency, result = operand1 + tag (doubling +1000, add +1). k=3 → job order double then add; o_qx = px+1001; exactly 2 o_pa_start pulses.
- Same model, k=2^254 → 254 doublings, 0 adds; k = all ones → 254 doublings and 254 adds, strictly alternating D,A; operands stable throughout every WAIT.
- Second i_start mid-run, plus a spurious i_pa_finished injected during an ISSUE state → first result unchanged, second start dropped, job count exact.
- i_rst asserted during DBL_WAIT, then a late i_pa_finished → all outputs 0, state IDLE; a following fresh k=3 run completes correctly.
